axis_pulse_gate: RTL and testbench

- Upstream stage of the pulse-measurement block.
- Watches the raw ADC sample stream for a threshold crossing, with hysteresis and a selectable edge.
- After each trigger, forwards exactly frame_length samples as one AXI-Stream frame, with tlast on the final sample, then discards samples for a holdoff interval.
- This gives the downstream offset/ramp/width counters a pulse-aligned time origin instead of a free-running one.

---
 rtl/axis_pulse_pkg.sv | 26 ++
 rtl/axis_pulse_gate_if.sv | 12 +
 rtl/axis_reg_slice.sv | 54 +++++
 rtl/axis_pulse_gate.sv | 158 +++++++++++++++
 tb/tb_axis_pulse_gate.sv | 268 ++++++++++++++++++++++++++
 5 files changed

// File: rtl/axis_pulse_pkg.sv
// Shared definitions for the pulse gate: FSM encodings, cfg_data layout and edge select.
// The measurement block's status decode imports the same package.
package axis_pulse_pkg;

  typedef enum logic [2:0] {
    ST_IDLE = 3'd0,
    ST_ARM  = 3'd1,
    ST_WAIT = 3'd2,
    ST_PASS = 3'd3,
    ST_HOLD = 3'd4
  } state_e;

  localparam int CFG_W         = 128;
  localparam int CFG_THR_LSB   = 0;
  localparam int CFG_THR_W     = 16;
  localparam int CFG_HYST_LSB  = 16;
  localparam int CFG_HYST_W    = 16;
  localparam int CFG_FRAME_LSB = 32;
  localparam int CFG_HOLD_LSB  = 64;
  localparam int CFG_EN_BIT    = 96;
  localparam int CFG_EDGE_BIT  = 97;

  localparam logic EDGE_RISING  = 1'b0;
  localparam logic EDGE_FALLING = 1'b1;

endpackage

// File: rtl/axis_pulse_gate_if.sv
// AXI-Stream bundle used for both the raw sample input and the gated frame output.
interface axis_pulse_gate_if #(
  parameter int AXIS_TDATA_WIDTH = 16
);
  logic [AXIS_TDATA_WIDTH-1:0] tdata;
  logic                        tvalid;
  logic                        tready;
  logic                        tlast;

  modport master (output tdata, output tvalid, output tlast, input tready);
  modport slave  (input tdata, input tvalid, output tready);
endinterface

// File: rtl/axis_reg_slice.sv
// One-deep AXI-Stream output register; accepts a new beat whenever empty or draining.
module axis_reg_slice #(
  parameter int AXIS_TDATA_WIDTH = 16
) (
  input  logic                        aclk,
  input  logic                        areset,
  input  logic [AXIS_TDATA_WIDTH-1:0] in_data,
  input  logic                        in_valid,
  input  logic                        in_last,
  output logic                        in_ready,
  output logic [AXIS_TDATA_WIDTH-1:0] out_data,
  output logic                        out_valid,
  output logic                        out_last,
  input  logic                        out_ready
);

  logic [AXIS_TDATA_WIDTH-1:0] data_q, data_d;
  logic                        vld_q, vld_d;
  logic                        last_q, last_d;
  logic                        load;

  assign in_ready = ~vld_q | out_ready;
  assign load     = in_valid & in_ready;

  always_comb begin
    vld_d  = vld_q;
    data_d = data_q;
    last_d = last_q;
    if (load) begin
      vld_d  = 1'b1;
      data_d = in_data;
      last_d = in_last;
    end else if (out_ready) begin
      vld_d = 1'b0;
    end
  end

  always_ff @(posedge aclk or posedge areset) begin
    if (areset) begin
      vld_q  <= 1'b0;
      data_q <= '0;
      last_q <= 1'b0;
    end else begin
      vld_q  <= vld_d;
      data_q <= data_d;
      last_q <= last_d;
    end
  end

  assign out_data  = data_q;
  assign out_valid = vld_q;
  assign out_last  = last_q;

endmodule

// File: rtl/axis_pulse_gate.sv
// Threshold-triggered frame gate: arms with hysteresis, forwards frame_length samples
// per trigger with tlast on the final one, then discards a holdoff interval.
module axis_pulse_gate
  import axis_pulse_pkg::*;
#(
  parameter int AXIS_TDATA_WIDTH = 16,
  parameter int CNTR_WIDTH       = 16
) (
  input  logic             aclk,
  input  logic             areset,
  input  logic [CFG_W-1:0] cfg_data,
  output logic             trig_out,
  output logic [2:0]       state_id,
  output logic [31:0]      sts_data,
  axis_pulse_gate_if.slave  s_axis,
  axis_pulse_gate_if.master m_axis
);

  // Two guard bits keep threshold +/- hysteresis from ever wrapping.
  localparam int CMP_W = ((AXIS_TDATA_WIDTH > CFG_THR_W) ? AXIS_TDATA_WIDTH : CFG_THR_W) + 2;

  state_e                  state_q, state_d;
  logic [CNTR_WIDTH-1:0]   cnt_q, cnt_d, cnt_inc;
  logic [CNTR_WIDTH-1:0]   frame_len_q, frame_len_d;
  logic [CNTR_WIDTH-1:0]   holdoff_q, holdoff_d;
  logic [31:0]             sts_q, sts_d;

  logic signed [CMP_W-1:0] thr_s, hyst_s, sample_s, arm_lvl_s;
  logic [CNTR_WIDTH-1:0]   cfg_frame, cfg_holdoff;
  logic                    cfg_en, cfg_edge;
  logic                    arm_hit, trig_hit;
  logic                    s_tready, beat, slice_ready;
  logic                    fwd_valid, fwd_last;
  logic                    unused_cfg;

  assign thr_s       = CMP_W'(signed'(cfg_data[CFG_THR_LSB +: CFG_THR_W]));
  assign hyst_s      = signed'(CMP_W'(cfg_data[CFG_HYST_LSB +: CFG_HYST_W]));
  assign sample_s    = CMP_W'(signed'(s_axis.tdata));
  assign cfg_frame   = cfg_data[CFG_FRAME_LSB +: CNTR_WIDTH];
  assign cfg_holdoff = cfg_data[CFG_HOLD_LSB +: CNTR_WIDTH];
  assign cfg_en      = cfg_data[CFG_EN_BIT];
  assign cfg_edge    = cfg_data[CFG_EDGE_BIT];
  assign unused_cfg  = ^cfg_data;

  assign arm_lvl_s = (cfg_edge == EDGE_FALLING) ? (thr_s + hyst_s) : (thr_s - hyst_s);
  assign arm_hit   = (cfg_edge == EDGE_FALLING) ? (sample_s > arm_lvl_s) : (sample_s < arm_lvl_s);
  assign trig_hit  = (cfg_edge == EDGE_FALLING) ? (sample_s <= thr_s) : (sample_s >= thr_s);

  // WAIT shares the output-register ready so a trigger sample is never dropped.
  assign s_tready = ((state_q == ST_WAIT) || (state_q == ST_PASS)) ? slice_ready : 1'b1;
  assign beat     = s_axis.tvalid & s_tready;
  assign cnt_inc  = cnt_q + CNTR_WIDTH'(1);

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    frame_len_d = frame_len_q;
    holdoff_d   = holdoff_q;
    sts_d       = sts_q;
    fwd_valid   = 1'b0;
    fwd_last    = 1'b0;
    trig_out    = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (cfg_en) state_d = ST_ARM;
      end
      ST_ARM: begin
        if (!cfg_en) state_d = ST_IDLE;
        else if (beat && arm_hit) state_d = ST_WAIT;
      end
      ST_WAIT: begin
        if (!cfg_en) begin
          state_d = ST_IDLE;
        end else if (beat && trig_hit) begin
          trig_out    = 1'b1;
          sts_d       = sts_q + 32'd1;
          frame_len_d = cfg_frame;
          holdoff_d   = cfg_holdoff;
          cnt_d       = '0;
          if (cfg_frame == '0) begin
            state_d = ST_HOLD;
          end else begin
            fwd_valid = 1'b1;
            fwd_last  = (cfg_frame == CNTR_WIDTH'(1));
            cnt_d     = fwd_last ? '0 : CNTR_WIDTH'(1);
            state_d   = fwd_last ? ST_HOLD : ST_PASS;
          end
        end
      end
      ST_PASS: begin
        // Enable is only consulted at the frame end so frames are never truncated.
        if (beat) begin
          fwd_valid = 1'b1;
          if (cnt_inc == frame_len_q) begin
            fwd_last = 1'b1;
            cnt_d    = '0;
            state_d  = cfg_en ? ST_HOLD : ST_IDLE;
          end else begin
            cnt_d = cnt_inc;
          end
        end
      end
      ST_HOLD: begin
        if (!cfg_en) begin
          state_d = ST_IDLE;
          cnt_d   = '0;
        end else if (holdoff_q == '0) begin
          state_d = ST_ARM;
        end else if (beat) begin
          if (cnt_inc == holdoff_q) begin
            state_d = ST_ARM;
            cnt_d   = '0;
          end else begin
            cnt_d = cnt_inc;
          end
        end
      end
      default: begin
        state_d = ST_IDLE;
        cnt_d   = '0;
      end
    endcase
  end

  always_ff @(posedge aclk or posedge areset) begin
    if (areset) begin
      state_q     <= ST_IDLE;
      cnt_q       <= '0;
      frame_len_q <= '0;
      holdoff_q   <= '0;
      sts_q       <= '0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      frame_len_q <= frame_len_d;
      holdoff_q   <= holdoff_d;
      sts_q       <= sts_d;
    end
  end

  axis_reg_slice #(.AXIS_TDATA_WIDTH(AXIS_TDATA_WIDTH)) u_out_slice (
    .aclk      (aclk),
    .areset    (areset),
    .in_data   (s_axis.tdata),
    .in_valid  (fwd_valid),
    .in_last   (fwd_last),
    .in_ready  (slice_ready),
    .out_data  (m_axis.tdata),
    .out_valid (m_axis.tvalid),
    .out_last  (m_axis.tlast),
    .out_ready (m_axis.tready)
  );

  assign s_axis.tready = s_tready;
  assign state_id      = state_q;
  assign sts_data      = sts_q;

endmodule

// File: tb/tb_axis_pulse_gate.sv
// Directed bench for axis_pulse_gate: expected output beats are queued as samples are
// driven and checked by a monitor as the DUT emits them.
module tb_axis_pulse_gate;

  logic         aclk = 1'b0;
  logic         areset;
  logic [127:0] cfg_data;
  logic         trig_out;
  logic [2:0]   state_id;
  logic [31:0]  sts_data;

  axis_pulse_gate_if #(.AXIS_TDATA_WIDTH(16)) s_if ();
  axis_pulse_gate_if #(.AXIS_TDATA_WIDTH(16)) m_if ();

  axis_pulse_gate #(.AXIS_TDATA_WIDTH(16), .CNTR_WIDTH(16)) dut (
    .aclk     (aclk),
    .areset   (areset),
    .cfg_data (cfg_data),
    .trig_out (trig_out),
    .state_id (state_id),
    .sts_data (sts_data),
    .s_axis   (s_if),
    .m_axis   (m_if)
  );

  always #5 aclk = ~aclk;

  int          checks = 0;
  int          errors = 0;
  logic [16:0] sb[$];
  logic [16:0] sb_head;
  bit          bp_en = 1'b0;
  bit          prev_held;
  logic [16:0] prev_out;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [127:0] mk_cfg(input int thr, input int hyst, input int frame,
                                          input int hold, input bit en, input bit fall);
    logic [127:0] c;
    c          = '0;
    c[15:0]    = 16'(thr);
    c[31:16]   = 16'(hyst);
    c[47:32]   = 16'(frame);
    c[79:64]   = 16'(hold);
    c[96]      = en;
    c[97]      = fall;
    return c;
  endfunction

  // Drive one sample until accepted; trig_out is checked on the accepting cycle.
  task automatic send(input int v, input bit exp_trig, input bit fwd, input bit last);
    int n;
    bit done;
    n    = 0;
    done = 1'b0;
    s_if.tdata  = 16'(v);
    s_if.tvalid = 1'b1;
    if (fwd) sb.push_back({last, 16'(v)});
    while (!done) begin
      @(negedge aclk);
      if (s_if.tready) begin
        chk("trig_out", 32'(trig_out), 32'(exp_trig));
        done = 1'b1;
      end else if (++n > 50) begin
        chk("send_timeout", 32'd0, 32'd1);
        done = 1'b1;
      end
      @(posedge aclk);
      #1;
    end
    s_if.tvalid = 1'b0;
  endtask

  task automatic drain();
    int n;
    n = 0;
    while (sb.size() != 0 && n < 60) begin
      @(posedge aclk);
      #1;
      n++;
    end
    repeat (2) @(posedge aclk);
    #1;
    chk("sb_drained", 32'(sb.size()), 32'd0);
  endtask

  task automatic cycles(input int n);
    repeat (n) @(posedge aclk);
    #1;
  endtask

  // m_axis_tready: always 1, or the 1,0,0 repeating pattern under back-pressure.
  initial begin
    int bp_cnt;
    bp_cnt      = 0;
    m_if.tready = 1'b1;
    forever begin
      @(posedge aclk);
      #1;
      m_if.tready = bp_en ? (bp_cnt % 3 == 0) : 1'b1;
      bp_cnt++;
    end
  end

  // Output monitor: scoreboard pop, hold stability and input ready under back-pressure.
  initial begin
    prev_held = 1'b0;
    prev_out  = '0;
    forever begin
      @(negedge aclk);
      if (areset) begin
        prev_held = 1'b0;
      end else begin
        if (prev_held && m_if.tvalid)
          chk("hold_stable", 32'({m_if.tlast, m_if.tdata}), 32'(prev_out));
        if (state_id == 3'd2 || state_id == 3'd3)
          chk("s_tready", 32'(s_if.tready), 32'(!(m_if.tvalid && !m_if.tready)));
        if (m_if.tvalid && m_if.tready) begin
          if (sb.size() == 0) begin
            chk("unexpected_beat", {15'd0, m_if.tlast, m_if.tdata}, 32'hFFFF_FFFF);
          end else begin
            sb_head = sb.pop_front();
            chk("m_tdata", 32'(m_if.tdata), 32'(sb_head[15:0]));
            chk("m_tlast", 32'(m_if.tlast), 32'(sb_head[16]));
          end
        end
        prev_held = m_if.tvalid && !m_if.tready;
        prev_out  = {m_if.tlast, m_if.tdata};
      end
    end
  end

  initial begin
    areset      = 1'b1;
    cfg_data    = '0;
    s_if.tdata  = '0;
    s_if.tvalid = 1'b0;
    s_if.tlast  = 1'b0;
    cycles(3);
    chk("rst_state", 32'(state_id), 32'd0);
    chk("rst_tvalid", 32'(m_if.tvalid), 32'd0);
    chk("rst_tlast", 32'(m_if.tlast), 32'd0);
    chk("rst_tdata", 32'(m_if.tdata), 32'd0);
    chk("rst_sts", sts_data, 32'd0);
    chk("rst_trig", 32'(trig_out), 32'd0);
    areset = 1'b0;

    // Rising trigger with frame 4, holdoff 3
    cfg_data = mk_cfg(100, 10, 4, 3, 1'b1, 1'b0);
    cycles(2);
    chk("t1_arm", 32'(state_id), 32'd1);
    send(-20, 0, 0, 0);
    chk("t1_wait", 32'(state_id), 32'd2);
    send(50, 0, 0, 0);
    send(95, 0, 0, 0);
    send(105, 1, 1, 0);
    send(110, 0, 1, 0);
    send(120, 0, 1, 0);
    send(130, 0, 1, 1);
    chk("t1_hold", 32'(state_id), 32'd4);
    send(140, 0, 0, 0);
    send(0, 0, 0, 0);
    send(0, 0, 0, 0);
    chk("t1_rearm", 32'(state_id), 32'd1);
    drain();
    chk("t1_sts", sts_data, 32'd1);

    // Hysteresis: after one trigger, samples above 90 never re-arm
    cfg_data = mk_cfg(100, 10, 1, 0, 1'b1, 1'b0);
    send(80, 0, 0, 0);
    send(95, 0, 0, 0);
    send(101, 1, 1, 1);
    send(99, 0, 0, 0);
    send(101, 0, 0, 0);
    chk("t2_state", 32'(state_id), 32'd1);
    drain();
    chk("t2_sts", sts_data, 32'd2);

    // Falling edge
    cfg_data = mk_cfg(0, 5, 2, 0, 1'b1, 1'b1);
    send(20, 0, 0, 0);
    send(3, 0, 0, 0);
    send(-1, 1, 1, 0);
    send(-4, 0, 1, 1);
    drain();
    chk("t3_sts", sts_data, 32'd3);
    chk("t3_state", 32'(state_id), 32'd1);

    // Back-pressure on the output
    cfg_data = mk_cfg(100, 10, 3, 0, 1'b1, 1'b0);
    bp_en = 1'b1;
    send(80, 0, 0, 0);
    send(100, 1, 1, 0);
    send(101, 0, 1, 0);
    send(102, 0, 1, 1);
    drain();
    bp_en = 1'b0;
    chk("t4_sts", sts_data, 32'd4);

    // Enable dropped mid-frame: frame completes, then IDLE
    cfg_data = mk_cfg(100, 10, 8, 0, 1'b1, 1'b0);
    cycles(1);
    send(80, 0, 0, 0);
    send(100, 1, 1, 0);
    send(101, 0, 1, 0);
    cfg_data = mk_cfg(100, 10, 8, 0, 1'b0, 1'b0);
    for (int i = 2; i <= 7; i++) send(100 + i, 0, 1, (i == 7));
    chk("t5_idle", 32'(state_id), 32'd0);
    send(80, 0, 0, 0);
    send(120, 0, 0, 0);
    drain();
    chk("t5_state", 32'(state_id), 32'd0);
    chk("t5_sts", sts_data, 32'd5);

    // Asynchronous reset in the middle of a frame
    cfg_data = mk_cfg(100, 10, 5, 0, 1'b1, 1'b0);
    cycles(2);
    send(80, 0, 0, 0);
    send(100, 1, 1, 0);
    send(101, 0, 1, 0);
    areset = 1'b1;
    #1;
    chk("t6_tvalid", 32'(m_if.tvalid), 32'd0);
    chk("t6_sts", sts_data, 32'd0);
    chk("t6_state", 32'(state_id), 32'd0);
    sb.delete();
    cycles(2);
    areset = 1'b0;
    cycles(2);
    chk("t6_arm", 32'(state_id), 32'd1);
    send(80, 0, 0, 0);
    for (int i = 0; i < 5; i++) send(110 + i, (i == 0), 1, (i == 4));
    drain();
    chk("t6_sts_after", sts_data, 32'd1);

    // Zero-length frame: trigger counted, nothing forwarded
    cfg_data = mk_cfg(100, 10, 0, 0, 1'b1, 1'b0);
    send(80, 0, 0, 0);
    send(105, 1, 0, 0);
    cycles(1);
    drain();
    chk("t7_sts", sts_data, 32'd2);
    chk("t7_state", 32'(state_id), 32'd1);

    // Arm levels at the numeric extremes must not wrap
    cfg_data = mk_cfg(32767, 65535, 2, 0, 1'b1, 1'b1);
    send(32767, 0, 0, 0);
    send(0, 0, 0, 0);
    chk("t7_fall_noarm", 32'(state_id), 32'd1);
    cfg_data = mk_cfg(-32768, 1, 2, 0, 1'b1, 1'b0);
    send(0, 0, 0, 0);
    send(-32768, 0, 0, 0);
    chk("t7_rise_noarm", 32'(state_id), 32'd1);
    drain();
    chk("t7_sts_final", sts_data, 32'd2);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
